cmd_cfg_nch: RTL and testbench

Parametrised command processor and configuration register file for the logic-analyzer core. It decodes 16-bit UART commands, reads and writes a register map sized to NUM_CH channels, and returns an ACK, a register value or a NAK to the host. It also sequences channel-RAM dumps itself: it generates the read addresses and wraps at ENTRIES. It sits between the UART command receiver/transmitter and the capture/trigger logic.

---
 rtl/cmd_cfg_pkg.sv | 54 +++++
 rtl/cmd_cfg_nch_if.sv | 30 +++
 rtl/dump_addr_gen.sv | 46 ++++
 rtl/cmd_cfg_nch.sv | 263 ++++++++++++++++++++++++++
 tb/tb_cmd_cfg_nch.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmd_cfg_pkg
// Brief    : Opcodes, register map, response codes and FSM states for cmd_cfg_nch.
//            CMD_DUMP_CKSUM_EN adds the CKSUM state.
// Revision : 1.0
// ============================================================================
package cmd_cfg_pkg;

   typedef enum logic [1:0] {
      OP_RD   = 2'b00,
      OP_WR   = 2'b01,
      OP_DMP  = 2'b10,
      OP_RSVD = 2'b11
   } opcode_t;

   localparam logic [5:0] ADDR_TRIG_CFG   = 6'h00;
   localparam logic [5:0] ADDR_CH_FIRST   = 6'h01;
   localparam logic [5:0] ADDR_DECIMATOR  = 6'h09;
   localparam logic [5:0] ADDR_VIH        = 6'h0A;
   localparam logic [5:0] ADDR_VIL        = 6'h0B;
   localparam logic [5:0] ADDR_MATCH_H    = 6'h0C;
   localparam logic [5:0] ADDR_MATCH_L    = 6'h0D;
   localparam logic [5:0] ADDR_MASK_H     = 6'h0E;
   localparam logic [5:0] ADDR_MASK_L     = 6'h0F;
   localparam logic [5:0] ADDR_BAUD_H     = 6'h10;
   localparam logic [5:0] ADDR_BAUD_L     = 6'h11;
   localparam logic [5:0] ADDR_TRIG_POS_H = 6'h12;
   localparam logic [5:0] ADDR_TRIG_POS_L = 6'h13;

   localparam logic [7:0] ACK = 8'hA5;
   localparam logic [7:0] NAK = 8'hEE;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RESP_WAIT = 3'd1,
      DMP_ADDR  = 3'd2,
      DMP_SEND  = 3'd3,
      DMP_WAIT  = 3'd4
`ifdef CMD_DUMP_CKSUM_EN
      ,
      CKSUM     = 3'd5
`endif
   } state_t;

   // Channel registers only exist for 1..num_ch; the 0x06..0x08 hole is invalid.
   function automatic logic reg_addr_valid(input logic [5:0] addr, input int num_ch);
      return (addr == ADDR_TRIG_CFG) ||
             ((addr >= ADDR_CH_FIRST) && (int'(addr) <= num_ch)) ||
             ((addr >= ADDR_DECIMATOR) && (addr <= ADDR_TRIG_POS_L));
   endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_cfg_nch_if.sv
`default_nettype none
// ============================================================================
// Module   : cmd_cfg_nch_if
// Brief    : UART command/response handshake and channel-RAM read port.
// Revision : 1.0
// ============================================================================
interface cmd_cfg_nch_if #(
   parameter int NUM_CH = 5,
   parameter int LOG2   = 9
);
   logic [15:0]         cmd;
   logic                cmd_rdy;
   logic                clr_cmd_rdy;
   logic [7:0]          resp;
   logic                send_resp;
   logic                resp_sent;
   logic [LOG2-1:0]     rd_addr;
   logic [8*NUM_CH-1:0] rdata;

   modport master (
      output cmd, cmd_rdy, resp_sent, rdata,
      input  clr_cmd_rdy, resp, send_resp, rd_addr
   );

   modport slave (
      input  cmd, cmd_rdy, resp_sent, rdata,
      output clr_cmd_rdy, resp, send_resp, rd_addr
   );
endinterface
`default_nettype wire

// File: rtl/dump_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : dump_addr_gen
// Brief    : Dump read-address sequencer wrapping at ENTRIES, with byte counter.
// Revision : 1.0
// ============================================================================
module dump_addr_gen #(
   parameter int ENTRIES = 384,
   parameter int LOG2    = 9
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   input  wire logic            load,
   input  wire logic            step,
   input  wire logic [LOG2-1:0] ram_addr,
   output logic      [LOG2-1:0] addr,
   output logic                 last
);
   localparam logic [LOG2-1:0] C_TOP = LOG2'(ENTRIES - 1);

   logic [LOG2-1:0] r_addr;
   logic [LOG2-1:0] r_cnt;

   function automatic logic [LOG2-1:0] wrap_inc(input logic [LOG2-1:0] a);
      return (a == C_TOP) ? '0 : a + LOG2'(1);
   endfunction

   // Dump starts at the oldest sample: one past the last capture write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_cnt  <= '0;
      end else if (load) begin
         r_addr <= wrap_inc(ram_addr);
         r_cnt  <= '0;
      end else if (step) begin
         r_addr <= wrap_inc(r_addr);
         r_cnt  <= r_cnt + LOG2'(1);
      end
   end

   assign addr = r_addr;
   assign last = (r_cnt == C_TOP);

endmodule
`default_nettype wire

// File: rtl/cmd_cfg_nch.sv
`default_nettype none
// ============================================================================
// Module   : cmd_cfg_nch
// Brief    : UART command decoder, config register file and channel-RAM dumper.
//            CMD_DUMP_CKSUM_EN appends a mod-256 checksum byte to each dump.
// Revision : 1.0
// ============================================================================
module cmd_cfg_nch
   import cmd_cfg_pkg::*;
#(
   parameter int NUM_CH  = 5,
   parameter int ENTRIES = 384,
   parameter int LOG2    = 9
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   cmd_cfg_nch_if.slave           bus,
   input  wire logic              set_capture_done,
   input  wire logic [LOG2-1:0]   ram_addr,
   output logic [5:0]             trig_cfg,
   output logic [5*NUM_CH-1:0]    ch_trig_cfg,
   output logic [3:0]             decimator,
   output logic [7:0]             VIH,
   output logic [7:0]             VIL,
   output logic [15:0]            match,
   output logic [15:0]            mask,
   output logic [15:0]            baud_cnt,
   output logic [LOG2-1:0]        trig_pos
);

   state_t          r_state, w_state_d;
   logic [7:0]      r_resp, w_resp_d;
   logic            r_send_resp, w_send_d;
   logic            r_clr_cmd_rdy, w_clr_d;
   logic [5:0]      r_dmp_ch;
   logic            w_accept, w_wr_en, w_load, w_step, w_last;
   logic [LOG2-1:0] w_rd_addr;
   logic [7:0]      w_rd_val, w_ch_byte;

   logic [5:0]      r_trig_cfg;
   logic [4:0]      r_ch_cfg [NUM_CH];
   logic [3:0]      r_decimator;
   logic [7:0]      r_vih, r_vil;
   logic [15:0]     r_match, r_mask, r_baud;
   logic [LOG2-1:0] r_trig_pos;

   opcode_t         w_op;
   logic [5:0]      w_addr;
   logic [7:0]      w_data;
   logic            w_addr_ok, w_ch_ok;

`ifdef CMD_DUMP_CKSUM_EN
   logic [7:0]      r_sum;
`endif

   assign w_op      = opcode_t'(bus.cmd[15:14]);
   assign w_addr    = bus.cmd[13:8];
   assign w_data    = bus.cmd[7:0];
   assign w_addr_ok = reg_addr_valid(w_addr, NUM_CH);
   assign w_ch_ok   = (w_addr != 6'd0) && (int'(w_addr) <= NUM_CH);
   // The clr pulse cycle still sees the old cmd_rdy; never re-accept it.
   assign w_accept  = (r_state == IDLE) && bus.cmd_rdy && !r_clr_cmd_rdy;

   always_comb begin
      w_rd_val = 8'h00;
      case (w_addr)
         ADDR_TRIG_CFG:   w_rd_val = {2'b00, r_trig_cfg};
         ADDR_DECIMATOR:  w_rd_val = {4'h0, r_decimator};
         ADDR_VIH:        w_rd_val = r_vih;
         ADDR_VIL:        w_rd_val = r_vil;
         ADDR_MATCH_H:    w_rd_val = r_match[15:8];
         ADDR_MATCH_L:    w_rd_val = r_match[7:0];
         ADDR_MASK_H:     w_rd_val = r_mask[15:8];
         ADDR_MASK_L:     w_rd_val = r_mask[7:0];
         ADDR_BAUD_H:     w_rd_val = r_baud[15:8];
         ADDR_BAUD_L:     w_rd_val = r_baud[7:0];
         ADDR_TRIG_POS_H: w_rd_val = 8'(r_trig_pos[LOG2-1:8]);
         ADDR_TRIG_POS_L: w_rd_val = r_trig_pos[7:0];
         default: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (int'(w_addr) == i + 1) w_rd_val = {3'b000, r_ch_cfg[i]};
            end
         end
      endcase
   end

   always_comb begin
      w_ch_byte = 8'h00;
      for (int i = 0; i < NUM_CH; i++) begin
         if (int'(r_dmp_ch) == i + 1) w_ch_byte = bus.rdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_d;
   end

   always_comb begin
      w_state_d = r_state;
      w_resp_d  = r_resp;
      w_send_d  = 1'b0;
      w_clr_d   = 1'b0;
      w_wr_en   = 1'b0;
      w_load    = 1'b0;
      w_step    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_send_d  = 1'b1;
               w_state_d = RESP_WAIT;
               w_resp_d  = NAK;
               case (w_op)
                  OP_RD: if (w_addr_ok) w_resp_d = w_rd_val;
                  OP_WR: if (w_addr_ok) begin
                     w_wr_en  = 1'b1;
                     w_resp_d = ACK;
                  end
                  OP_DMP: if (w_ch_ok) begin
                     w_send_d  = 1'b0;
                     w_resp_d  = r_resp;
                     w_load    = 1'b1;
                     w_state_d = DMP_ADDR;
                  end
                  default: ;
               endcase
            end
         end
         RESP_WAIT: begin
            if (bus.resp_sent) begin
               w_clr_d   = 1'b1;
               w_state_d = IDLE;
            end
         end
         DMP_ADDR: w_state_d = DMP_SEND;
         DMP_SEND: begin
            w_resp_d  = w_ch_byte;
            w_send_d  = 1'b1;
            w_state_d = DMP_WAIT;
         end
         DMP_WAIT: begin
            if (bus.resp_sent) begin
               w_step    = 1'b1;
               w_state_d = DMP_ADDR;
               if (w_last) begin
`ifdef CMD_DUMP_CKSUM_EN
                  w_resp_d  = r_sum;
                  w_send_d  = 1'b1;
                  w_state_d = CKSUM;
`else
                  w_clr_d   = 1'b1;
                  w_state_d = IDLE;
`endif
               end
            end
         end
`ifdef CMD_DUMP_CKSUM_EN
         CKSUM: begin
            if (bus.resp_sent) begin
               w_clr_d   = 1'b1;
               w_state_d = IDLE;
            end
         end
`endif
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp        <= 8'h00;
         r_send_resp   <= 1'b0;
         r_clr_cmd_rdy <= 1'b0;
         r_dmp_ch      <= 6'd0;
      end else begin
         r_resp        <= w_resp_d;
         r_send_resp   <= w_send_d;
         r_clr_cmd_rdy <= w_clr_d;
         if (w_accept) r_dmp_ch <= w_addr;
      end
   end

`ifdef CMD_DUMP_CKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_sum <= 8'h00;
      else if (w_load)             r_sum <= 8'h00;
      else if (r_state == DMP_SEND) r_sum <= r_sum + w_ch_byte;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_trig_cfg  <= 6'h03;
         for (int i = 0; i < NUM_CH; i++) r_ch_cfg[i] <= 5'h01;
         r_decimator <= 4'h0;
         r_vih       <= 8'hAA;
         r_vil       <= 8'h55;
         r_match     <= 16'h0000;
         r_mask      <= 16'h0000;
         r_baud      <= 16'h06C8;
         r_trig_pos  <= LOG2'(1);
      end else begin
         if (w_wr_en) begin
            case (w_addr)
               ADDR_TRIG_CFG:   r_trig_cfg          <= w_data[5:0];
               ADDR_DECIMATOR:  r_decimator         <= w_data[3:0];
               ADDR_VIH:        r_vih               <= w_data;
               ADDR_VIL:        r_vil               <= w_data;
               ADDR_MATCH_H:    r_match[15:8]       <= w_data;
               ADDR_MATCH_L:    r_match[7:0]        <= w_data;
               ADDR_MASK_H:     r_mask[15:8]        <= w_data;
               ADDR_MASK_L:     r_mask[7:0]         <= w_data;
               ADDR_BAUD_H:     r_baud[15:8]        <= w_data;
               ADDR_BAUD_L:     r_baud[7:0]         <= w_data;
               ADDR_TRIG_POS_H: r_trig_pos[LOG2-1:8] <= w_data[LOG2-9:0];
               ADDR_TRIG_POS_L: r_trig_pos[7:0]     <= w_data;
               default: begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (int'(w_addr) == i + 1) r_ch_cfg[i] <= w_data[4:0];
                  end
               end
            endcase
         end
         // Later assignment: capture_done set beats a same-cycle write of 0.
         if (set_capture_done) r_trig_cfg[5] <= 1'b1;
      end
   end

   dump_addr_gen #(
      .ENTRIES (ENTRIES),
      .LOG2    (LOG2)
   ) u_dump_addr_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_load),
      .step     (w_step),
      .ram_addr (ram_addr),
      .addr     (w_rd_addr),
      .last     (w_last)
   );

   assign bus.rd_addr     = w_rd_addr;
   assign bus.resp        = r_resp;
   assign bus.send_resp   = r_send_resp;
   assign bus.clr_cmd_rdy = r_clr_cmd_rdy;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign ch_trig_cfg[5*gi +: 5] = r_ch_cfg[gi];
      end
   endgenerate

   assign trig_cfg  = r_trig_cfg;
   assign decimator = r_decimator;
   assign VIH       = r_vih;
   assign VIL       = r_vil;
   assign match     = r_match;
   assign mask      = r_mask;
   assign baud_cnt  = r_baud;
   assign trig_pos  = r_trig_pos;

endmodule
`default_nettype wire

// File: tb/tb_cmd_cfg_nch.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_cfg_nch
// Brief    : Directed table-driven bench for cmd_cfg_nch (NUM_CH=5, ENTRIES=384).
// Revision : 1.0
// ============================================================================
module tb_cmd_cfg_nch;
   localparam int NUM_CH  = 5;
   localparam int ENTRIES = 384;
   localparam int LOG2    = 9;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              set_capture_done;
   logic [LOG2-1:0]   ram_addr;
   logic [5:0]        trig_cfg;
   logic [5*NUM_CH-1:0] ch_trig_cfg;
   logic [3:0]        decimator;
   logic [7:0]        VIH, VIL;
   logic [15:0]       match, mask, baud_cnt;
   logic [LOG2-1:0]   trig_pos;

   int n_vec = 0;
   int n_fail = 0;
   int exp_clr = 0;
   int clr_seen = 0;

   cmd_cfg_nch_if #(.NUM_CH(NUM_CH), .LOG2(LOG2)) bus ();

   cmd_cfg_nch #(.NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .bus              (bus),
      .set_capture_done (set_capture_done),
      .ram_addr         (ram_addr),
      .trig_cfg         (trig_cfg),
      .ch_trig_cfg      (ch_trig_cfg),
      .decimator        (decimator),
      .VIH              (VIH),
      .VIL              (VIL),
      .match            (match),
      .mask             (mask),
      .baud_cnt         (baud_cnt),
      .trig_pos         (trig_pos)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ram_byte(input int ch, input int a);
      return 8'((a * 7 + ch * 29) ^ (a >> 5));
   endfunction

   // Synchronous channel RAM: data for rd_addr is valid one cycle later.
   always @(posedge clk) begin
      for (int n = 1; n <= NUM_CH; n++)
         bus.rdata[8*(n-1) +: 8] <= ram_byte(n, int'(bus.rd_addr));
   end

   always @(posedge clk) if (bus.clr_cmd_rdy === 1'b1) clr_seen++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_cmd(input logic [15:0] c, input logic [7:0] exp, input bit scd, input string nm);
      int w;
      @(negedge clk);
      bus.cmd = c;
      bus.cmd_rdy = 1'b1;
      set_capture_done = scd;
      w = 0;
      do begin
         @(negedge clk);
         set_capture_done = 1'b0;
         w++;
      end while (bus.send_resp !== 1'b1 && w < 20);
      check({nm, " latency"}, w, 1);
      check({nm, " resp"}, bus.resp, exp);
      repeat (2) @(negedge clk);
      bus.resp_sent = 1'b1;
      @(negedge clk);
      bus.resp_sent = 1'b0;
      check({nm, " clr"}, bus.clr_cmd_rdy, 1);
      bus.cmd_rdy = 1'b0;
      exp_clr++;
   endtask

   task automatic do_dump(input int ch, input int ra, input int abort_after, input string nm);
      int w;
      int a;
      logic [7:0] b;
      logic [7:0] sum;
      @(negedge clk);
      ram_addr = LOG2'(ra);
      bus.cmd = {2'b10, 6'(ch), 8'h00};
      bus.cmd_rdy = 1'b1;
      sum = 8'h00;
      a = (ra == ENTRIES - 1) ? 0 : ra + 1;
      for (int k = 0; k < ENTRIES; k++) begin
         w = 0;
         do begin
            @(negedge clk);
            w++;
            // The command word must have been captured on acceptance.
            if (k == 0 && w == 1) bus.cmd = 16'h8100;
         end while (bus.send_resp !== 1'b1 && w < 20);
         check({nm, " latency"}, w, (k == 0) ? 3 : 2);
         check({nm, " rd_addr"}, 32'(bus.rd_addr), a);
         b = ram_byte(ch, a);
         check({nm, " byte"}, bus.resp, b);
         sum = sum + b;
         if (k == abort_after) begin
            #2 rst_n = 1'b0;
            #1;
            check({nm, " rst send_resp"}, bus.send_resp, 0);
            check({nm, " rst rd_addr"}, 32'(bus.rd_addr), 0);
            check({nm, " rst resp"}, bus.resp, 0);
            check({nm, " rst trig_cfg"}, trig_cfg, 6'h03);
            check({nm, " rst vih"}, VIH, 8'hAA);
            bus.cmd_rdy = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check({nm, " rst clr"}, bus.clr_cmd_rdy, 0);
            return;
         end
         bus.resp_sent = 1'b1;
         @(negedge clk);
         bus.resp_sent = 1'b0;
         a = (a == ENTRIES - 1) ? 0 : a + 1;
      end
`ifdef CMD_DUMP_CKSUM_EN
      check({nm, " cksum send"}, bus.send_resp, 1);
      check({nm, " cksum"}, bus.resp, sum);
      check({nm, " cksum noclr"}, bus.clr_cmd_rdy, 0);
      @(negedge clk);
      bus.resp_sent = 1'b1;
      @(negedge clk);
      bus.resp_sent = 1'b0;
`endif
      check({nm, " clr"}, bus.clr_cmd_rdy, 1);
      bus.cmd_rdy = 1'b0;
      exp_clr++;
   endtask

   typedef struct {
      logic [1:0] op;
      logic [5:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t vt [27];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      vt[0]  = '{2'b00, 6'h0A, 8'h00, 8'hAA};
      vt[1]  = '{2'b00, 6'h0B, 8'h00, 8'h55};
      vt[2]  = '{2'b00, 6'h11, 8'h00, 8'hC8};
      vt[3]  = '{2'b00, 6'h10, 8'h00, 8'h06};
      vt[4]  = '{2'b00, 6'h00, 8'h00, 8'h03};
      vt[5]  = '{2'b00, 6'h13, 8'h00, 8'h01};
      vt[6]  = '{2'b00, 6'h12, 8'h00, 8'h00};
      vt[7]  = '{2'b00, 6'h03, 8'h00, 8'h01};
      vt[8]  = '{2'b00, 6'h06, 8'h00, 8'hEE};
      vt[9]  = '{2'b00, 6'h14, 8'h00, 8'hEE};
      vt[10] = '{2'b01, 6'h0C, 8'h3C, 8'hA5};
      vt[11] = '{2'b00, 6'h0C, 8'h00, 8'h3C};
      vt[12] = '{2'b01, 6'h07, 8'h1F, 8'hEE};
      vt[13] = '{2'b01, 6'h05, 8'hFF, 8'hA5};
      vt[14] = '{2'b00, 6'h05, 8'h00, 8'h1F};
      vt[15] = '{2'b00, 6'h04, 8'h00, 8'h01};
      vt[16] = '{2'b01, 6'h09, 8'hF7, 8'hA5};
      vt[17] = '{2'b00, 6'h09, 8'h00, 8'h07};
      vt[18] = '{2'b01, 6'h12, 8'hFF, 8'hA5};
      vt[19] = '{2'b00, 6'h12, 8'h00, 8'h01};
      vt[20] = '{2'b11, 6'h00, 8'h00, 8'hEE};
      vt[21] = '{2'b01, 6'h0A, 8'h12, 8'hA5};
      vt[22] = '{2'b00, 6'h0A, 8'h00, 8'h12};
      vt[23] = '{2'b10, 6'h00, 8'h00, 8'hEE};
      vt[24] = '{2'b10, 6'h06, 8'h00, 8'hEE};
      vt[25] = '{2'b01, 6'h0F, 8'h81, 8'hA5};
      vt[26] = '{2'b00, 6'h0F, 8'h00, 8'h81};

      rst_n = 1'b0;
      set_capture_done = 1'b0;
      ram_addr = '0;
      bus.cmd = 16'h0000;
      bus.cmd_rdy = 1'b0;
      bus.resp_sent = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("reset resp", bus.resp, 8'h00);
      check("reset send_resp", bus.send_resp, 0);
      check("reset clr", bus.clr_cmd_rdy, 0);
      check("reset rd_addr", 32'(bus.rd_addr), 0);
      check("reset trig_cfg", trig_cfg, 6'h03);
      check("reset ch_trig_cfg", ch_trig_cfg, {5{5'h01}});
      check("reset baud_cnt", baud_cnt, 16'h06C8);
      check("reset trig_pos", 32'(trig_pos), 1);
      check("reset vih_vil", {VIH, VIL}, 16'hAA55);

      for (int i = 0; i < 27; i++)
         do_cmd({vt[i].op, vt[i].addr, vt[i].data}, vt[i].exp, 1'b0, $sformatf("vec%0d", i));

      check("ch_trig_cfg after writes", ch_trig_cfg, {5'h1F, 5'h01, 5'h01, 5'h01, 5'h01});
      check("decimator", decimator, 4'h7);
      check("trig_pos", 32'(trig_pos), 9'h101);
      check("match", match, 16'h3C00);
      check("mask", mask, 16'h0081);
      check("vih", VIH, 8'h12);

      do_cmd(16'h4001, 8'hA5, 1'b1, "wr_tc_with_set");
      check("capture_done set wins", trig_cfg, 6'h21);
      do_cmd(16'h0000, 8'h21, 1'b0, "rd_tc");
      do_cmd(16'h4000, 8'hA5, 1'b0, "wr_tc_zero");
      check("trig_cfg cleared", trig_cfg, 6'h00);
      @(negedge clk);
      set_capture_done = 1'b1;
      @(negedge clk);
      set_capture_done = 1'b0;
      check("capture_done alone", trig_cfg, 6'h20);

      do_dump(3, ENTRIES - 1, -1, "dmp_ch3");
      do_dump(5, 100, -1, "dmp_ch5_wrap");
      do_dump(2, 10, 3, "dmp_abort");
      do_cmd(16'h0000, 8'h03, 1'b0, "rd_tc_after_rst");

      repeat (3) @(negedge clk);
      check("clr_cmd_rdy pulse count", clr_seen, exp_clr);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
